// File: rtl/vdp_super_palette_if.sv
// vdp_super_palette_if
//   Bundles the CPU load port, the video read index and the palette colour
//   outputs of the super-res palette stage.
//   master : CPU/fetcher side (drives cpu_wr/cpu_port/cpu_data/PALETTE_ADDR2)
//   slave  : palette stage (drives R/G/B outputs and init_busy)
interface vdp_super_palette_if;
  logic       cpu_wr;
  logic       cpu_port;
  logic [7:0] cpu_data;
  logic [7:0] PALETTE_ADDR2;
  logic [7:0] PALETTE_DATA_R2_OUT;
  logic [7:0] PALETTE_DATA_G2_OUT;
  logic [7:0] PALETTE_DATA_B2_OUT;
  logic       init_busy;

  modport master (
    output cpu_wr, cpu_port, cpu_data, PALETTE_ADDR2,
    input  PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT, init_busy
  );

  modport slave (
    input  cpu_wr, cpu_port, cpu_data, PALETTE_ADDR2,
    output PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT, init_busy
  );
endinterface

// File: rtl/vdp_super_palette.sv
// vdp_super_palette
//   256 x 24-bit palette RAM for the super-res video path. Video index in,
//   registered R/G/B out one clock later. CPU loads entries as an index write
//   followed by R, G, B data bytes; the index auto-increments after each B.
//   After reset a sequencer fills the RAM with a G3R3B2 default ramp.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : vdp_super_palette_if.slave
//              cpu_wr/cpu_port/cpu_data : CPU write strobe, register select, data
//              PALETTE_ADDR2            : video read index
//              PALETTE_DATA_*2_OUT      : colour of the index sampled last edge
//              init_busy                : high while the default ramp is written
module vdp_super_palette #(
  parameter int INIT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            reset_n,
  vdp_super_palette_if.slave bus
);

  typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_B = 2'd2} phase_t;

  // Default entry: 3-3-2 fields replicated out to 8 bits per channel.
  function automatic logic [23:0] default_entry(input logic [7:0] i);
    logic [7:0] r, g, b;
    r = {i[4:2], i[4:2], i[4:3]};
    g = {i[7:5], i[7:5], i[7:6]};
    b = {i[1:0], i[1:0], i[1:0], i[1:0]};
    return {r, g, b};
  endfunction

  logic [23:0] ram [256];

  logic        init_busy_q;
  logic [7:0]  init_addr_q;
  logic        init_last;

  phase_t      phase_q, phase_d;
  logic [7:0]  index_q;
  logic [7:0]  stg_r_q, stg_g_q;
  logic        cpu_act;
  logic        ld_r, ld_g, commit;

  logic        ram_we;
  logic [7:0]  ram_waddr;
  logic [23:0] ram_wdata;

  logic [23:0] rgb_p1;
  logic        rd_en;

  assign init_last = (init_addr_q == 8'(INIT_CYCLES - 1));
  // CPU strobes are dropped entirely while the ramp is being written.
  assign cpu_act   = bus.cpu_wr && !init_busy_q;

  // Init sequencer: one default entry per clock; the edge writing the last
  // entry also drops busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_busy_q <= 1'b1;
      init_addr_q <= 8'd0;
    end else if (init_busy_q) begin
      init_addr_q <= init_addr_q + 8'd1;
      if (init_last) init_busy_q <= 1'b0;
    end
  end

  // Byte-phase FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= PH_R;
    else          phase_q <= phase_d;
  end

  // Byte-phase FSM: next state. An index write always restarts the triplet.
  always_comb begin
    phase_d = phase_q;
    if (cpu_act) begin
      if (!bus.cpu_port) begin
        phase_d = PH_R;
      end else begin
        case (phase_q)
          PH_R:    phase_d = PH_G;
          PH_G:    phase_d = PH_B;
          default: phase_d = PH_R;
        endcase
      end
    end
  end

  // Byte-phase FSM: outputs
  always_comb begin
    ld_r   = 1'b0;
    ld_g   = 1'b0;
    commit = 1'b0;
    if (cpu_act && bus.cpu_port) begin
      case (phase_q)
        PH_R:    ld_r   = 1'b1;
        PH_G:    ld_g   = 1'b1;
        default: commit = 1'b1;
      endcase
    end
  end

  // CPU index and staged colour bytes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_q <= 8'd0;
      stg_r_q <= 8'd0;
      stg_g_q <= 8'd0;
    end else begin
      if (cpu_act && !bus.cpu_port) index_q <= bus.cpu_data;
      else if (commit)              index_q <= index_q + 8'd1;
      if (ld_r) stg_r_q <= bus.cpu_data;
      if (ld_g) stg_g_q <= bus.cpu_data;
    end
  end

  // Single RAM write port shared by the init sequencer and CPU commits.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = index_q;
    ram_wdata = {stg_r_q, stg_g_q, bus.cpu_data};
    if (init_busy_q) begin
      ram_we    = 1'b1;
      ram_waddr = init_addr_q;
      ram_wdata = default_entry(init_addr_q);
    end else if (commit) begin
      ram_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // ---- stage p1: registered video read (read-before-write on collision) ----
  // The edge that finishes init already samples a real read.
  assign rd_en = !init_busy_q || init_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rgb_p1 <= 24'd0;
    else if (rd_en) rgb_p1 <= ram[bus.PALETTE_ADDR2];
    else            rgb_p1 <= 24'd0;
  end

  assign bus.PALETTE_DATA_R2_OUT = rgb_p1[23:16];
  assign bus.PALETTE_DATA_G2_OUT = rgb_p1[15:8];
  assign bus.PALETTE_DATA_B2_OUT = rgb_p1[7:0];
  assign bus.init_busy           = init_busy_q;

endmodule

// File: tb/tb_vdp_super_palette.sv
module tb_vdp_super_palette;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  vdp_super_palette_if bus ();

  vdp_super_palette #(.INIT_CYCLES(256)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  vec_t dflt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic port, input logic [7:0] data);
    bus.cpu_wr   = 1'b1;
    bus.cpu_port = port;
    bus.cpu_data = data;
    tick();
    bus.cpu_wr   = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [7:0] addr,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.PALETTE_ADDR2 = addr;
    tick();
    check(name, {8'h0, bus.PALETTE_DATA_R2_OUT, bus.PALETTE_DATA_G2_OUT, bus.PALETTE_DATA_B2_OUT},
          {8'h0, r, g, b});
  endtask

  task automatic wait_init(input string name);
    int cnt;
    cnt = 0;
    while (bus.init_busy && cnt < 300) begin
      tick();
      cnt++;
    end
    check({name, "_init_done"}, {31'd0, bus.init_busy}, 32'd0);
  endtask

  task automatic check_defaults(input string name);
    for (int i = 0; i < 8; i++)
      rd_check($sformatf("%s_dflt%02h", name, dflt[i].addr), dflt[i].addr,
               dflt[i].r, dflt[i].g, dflt[i].b);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // addr, R, G, B computed from R={i[4:2],i[4:2],i[4:3]}, G={i[7:5],i[7:5],i[7:6]}, B=i[1:0]x4
    dflt[0] = '{8'h00, 8'h00, 8'h00, 8'h00};
    dflt[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    dflt[2] = '{8'h1C, 8'hFF, 8'h00, 8'h00};
    dflt[3] = '{8'hE0, 8'h00, 8'hFF, 8'h00};
    dflt[4] = '{8'h03, 8'h00, 8'h00, 8'hFF};
    dflt[5] = '{8'h05, 8'h24, 8'h00, 8'h55};
    dflt[6] = '{8'hA7, 8'h24, 8'hB6, 8'hFF};
    dflt[7] = '{8'h30, 8'h92, 8'h24, 8'h00};

    bus.cpu_wr        = 1'b0;
    bus.cpu_port      = 1'b0;
    bus.cpu_data      = 8'h00;
    bus.PALETTE_ADDR2 = 8'h00;
    reset_n           = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, bus.init_busy}, 32'd1);
    check("rst_rgb", {8'h0, bus.PALETTE_DATA_R2_OUT, bus.PALETTE_DATA_G2_OUT, bus.PALETTE_DATA_B2_OUT}, 32'd0);

    // Init length: busy still high after 255 edges, low after the 256th.
    bus.PALETTE_ADDR2 = 8'hFF;
    reset_n = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    check("busy_at_255", {31'd0, bus.init_busy}, 32'd1);
    check("rgb_zero_in_init", {8'h0, bus.PALETTE_DATA_R2_OUT, bus.PALETTE_DATA_G2_OUT, bus.PALETTE_DATA_B2_OUT}, 32'd0);
    tick();
    check("busy_at_256", {31'd0, bus.init_busy}, 32'd0);
    check_defaults("init");

    // Basic triplet load and auto-increment.
    wr(1'b0, 8'h10);
    wr(1'b1, 8'h12); wr(1'b1, 8'h34); wr(1'b1, 8'h56);
    wr(1'b1, 8'hAA); wr(1'b1, 8'hBB); wr(1'b1, 8'hCC);
    rd_check("load_10", 8'h10, 8'h12, 8'h34, 8'h56);
    rd_check("load_11", 8'h11, 8'hAA, 8'hBB, 8'hCC);

    // Index wrap from 0xFF to 0x00, then index lands on 0x01.
    wr(1'b0, 8'hFF);
    wr(1'b1, 8'h01); wr(1'b1, 8'h02); wr(1'b1, 8'h03);
    wr(1'b1, 8'h04); wr(1'b1, 8'h05); wr(1'b1, 8'h06);
    wr(1'b1, 8'h07); wr(1'b1, 8'h08); wr(1'b1, 8'h09);
    rd_check("wrap_ff", 8'hFF, 8'h01, 8'h02, 8'h03);
    rd_check("wrap_00", 8'h00, 8'h04, 8'h05, 8'h06);
    rd_check("wrap_01", 8'h01, 8'h07, 8'h08, 8'h09);

    // Aborted triplet never reaches the RAM.
    wr(1'b0, 8'h20);
    wr(1'b1, 8'h11); wr(1'b1, 8'h22);
    rd_check("partial_20", 8'h20, 8'h00, 8'h24, 8'h00);
    wr(1'b0, 8'h20);
    rd_check("partial_20b", 8'h20, 8'h00, 8'h24, 8'h00);
    wr(1'b1, 8'h77); wr(1'b1, 8'h88); wr(1'b1, 8'h99);
    rd_check("restart_20", 8'h20, 8'h77, 8'h88, 8'h99);

    // Collision: commit to 0x30 while reading 0x30 on the same edge.
    bus.PALETTE_ADDR2 = 8'h30;
    wr(1'b0, 8'h30);
    wr(1'b1, 8'hC1); wr(1'b1, 8'hC2);
    wr(1'b1, 8'hC3);
    check("coll_old", {8'h0, bus.PALETTE_DATA_R2_OUT, bus.PALETTE_DATA_G2_OUT, bus.PALETTE_DATA_B2_OUT},
          32'h00922400);
    tick();
    check("coll_new", {8'h0, bus.PALETTE_DATA_R2_OUT, bus.PALETTE_DATA_G2_OUT, bus.PALETTE_DATA_B2_OUT},
          32'h00C1C2C3);

    // CPU writes during init are ignored; index stays 0 afterwards.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    wr(1'b0, 8'h05);
    wr(1'b1, 8'h01); wr(1'b1, 8'h02); wr(1'b1, 8'h03);
    wait_init("cpu_in_init");
    rd_check("init_ign_05", 8'h05, 8'h24, 8'h00, 8'h55);
    wr(1'b1, 8'hDE); wr(1'b1, 8'hAD); wr(1'b1, 8'hBE);
    rd_check("post_init_00", 8'h00, 8'hDE, 8'hAD, 8'hBE);

    // Reset mid-triplet: staged bytes, phase and index all lost.
    wr(1'b0, 8'h40);
    wr(1'b1, 8'h01); wr(1'b1, 8'h02);
    reset_n = 1'b0;
    #2;
    check("midrst_busy", {31'd0, bus.init_busy}, 32'd1);
    check("midrst_rgb", {8'h0, bus.PALETTE_DATA_R2_OUT, bus.PALETTE_DATA_G2_OUT, bus.PALETTE_DATA_B2_OUT}, 32'd0);
    reset_n = 1'b1;
    wait_init("midrst");
    check_defaults("rerun");
    rd_check("midrst_40", 8'h40, 8'h00, 8'h49, 8'h00);
    wr(1'b1, 8'h0A); wr(1'b1, 8'h0B); wr(1'b1, 8'h0C);
    rd_check("midrst_00", 8'h00, 8'h0A, 8'h0B, 8'h0C);
    rd_check("midrst_01", 8'h01, 8'h00, 8'h00, 8'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
